// File: rtl/pulse_stretcher.sv
// Per-channel output conditioner: every level change on stretch_out is held for
// at least hold_cycles clocks; input changes during a hold are replayed afterwards.
module pulse_stretcher #(
  parameter int nr_channels = 8,
  parameter int hold_cycles = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nr_channels-1:0] stretch_in,
  output logic [nr_channels-1:0] stretch_out,
  output logic [nr_channels-1:0] edge_out,
  output logic [nr_channels-1:0] busy
);

  localparam int CW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam logic [CW-1:0] LOAD = CW'(hold_cycles - 1);

  logic [nr_channels-1:0] out_q;
  logic [nr_channels-1:0] pend_q;
  logic [nr_channels-1:0] edge_q;
  logic [CW-1:0]          cnt_q [nr_channels];

  for (genvar i = 0; i < nr_channels; i++) begin : g_ch
    always_ff @(posedge clock) begin
      if (reset) begin
        out_q[i]  <= 1'b0;
        cnt_q[i]  <= '0;
        pend_q[i] <= 1'b0;
        edge_q[i] <= 1'b0;
      end else if (cnt_q[i] == '0) begin
        // A pending event toggles even if the input already came back: that is the stretch.
        if ((stretch_in[i] != out_q[i]) || pend_q[i]) begin
          out_q[i]  <= ~out_q[i];
          cnt_q[i]  <= LOAD;
          pend_q[i] <= 1'b0;
          edge_q[i] <= 1'b1;
        end else begin
          edge_q[i] <= 1'b0;
        end
      end else begin
        cnt_q[i]  <= cnt_q[i] - 1'b1;
        edge_q[i] <= 1'b0;
        if (stretch_in[i] != out_q[i]) pend_q[i] <= 1'b1;
      end
    end

    assign busy[i] = (cnt_q[i] != '0);
  end

  assign stretch_out = out_q;
  assign edge_out    = edge_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: hold_cycles=4 x 8 channels, plus a
// hold_cycles=1 x 4 channels instance for the pass-through case.
module tb_pulse_stretcher;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sin   = '0;
  logic [7:0] sout, seout, sbusy;
  logic [3:0] s1in  = '0;
  logic [3:0] s1out, s1edge, s1busy;

  int vectors = 0;
  int errs    = 0;

  always #5 clock = ~clock;

  pulse_stretcher #(.nr_channels(8), .hold_cycles(4)) dut (
    .clock(clock), .reset(reset), .stretch_in(sin),
    .stretch_out(sout), .edge_out(seout), .busy(sbusy)
  );

  pulse_stretcher #(.nr_channels(4), .hold_cycles(1)) dut1 (
    .clock(clock), .reset(reset), .stretch_in(s1in),
    .stretch_out(s1out), .edge_out(s1edge), .busy(s1busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int gap;
    int changes;
    logic prev;
    logic [3:0] last1;

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_out", 32'(sout), 0);
    chk("rst_edge", 32'(seout), 0);
    chk("rst_busy", 32'(sbusy), 0);
    chk("rst1_out", 32'(s1out), 0);
    reset = 1'b0;
    tick();
    chk("idle_out", 32'(sout), 0);

    // 1: step on channel 0
    sin[0] = 1'b1;
    tick();
    chk("t1_out", 32'(sout), 32'h01);
    chk("t1_edge", 32'(seout), 32'h01);
    chk("t1_busy_a", 32'(sbusy), 32'h01);
    tick();
    chk("t1_edge_off", 32'(seout), 0);
    chk("t1_busy_b", 32'(sbusy), 32'h01);
    tick();
    chk("t1_busy_c", 32'(sbusy), 32'h01);
    tick();
    chk("t1_busy_end", 32'(sbusy), 0);
    chk("t1_hold", 32'(sout), 32'h01);

    // 2: one-cycle pulse on channel 2 stretched to 4 cycles
    sin[2] = 1'b1;
    tick();
    chk("t2_rise", 32'(sout[2]), 1);
    chk("t2_edge1", 32'(seout), 32'h04);
    sin[2] = 1'b0;
    tick();
    chk("t2_hold1", 32'(sout[2]), 1);
    tick();
    tick();
    chk("t2_hold3", 32'(sout[2]), 1);
    chk("t2_noedge", 32'(seout[2]), 0);
    tick();
    chk("t2_fall", 32'(sout[2]), 0);
    chk("t2_edge2", 32'(seout[2]), 1);
    tick();
    chk("t2_edge2_off", 32'(seout[2]), 0);
    chk("t2_ch0", 32'(sout), 32'h01);

    // 3: pulse during hold on channel 1
    sin[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_pre", 32'(sout[1]), 1);
    sin[1] = 1'b0;
    tick();                              // N
    chk("t3_fall", 32'(sout[1]), 0);
    sin[1] = 1'b1;
    tick();                              // N+1: pending sets
    sin[1] = 1'b0;
    tick(); tick();                      // N+3
    chk("t3_frozen", 32'(sout[1]), 0);
    tick();                              // N+4
    chk("t3_rise", 32'(sout[1]), 1);
    chk("t3_edge", 32'(seout[1]), 1);
    tick(); tick(); tick();              // N+7
    chk("t3_hold", 32'(sout[1]), 1);
    tick();                              // N+8
    chk("t3_back", 32'(sout[1]), 0);

    // 4: fast toggling on channel 3
    gap = 100;
    changes = 0;
    prev = sout[3];
    for (int i = 0; i < 48; i++) begin
      if (i < 40) sin[3] = ~sin[3];
      tick();
      if (sout[3] !== prev) begin
        chk("t4_gap_ge4", 32'(gap >= 4), 1);
        gap = 1;
        changes++;
        prev = sout[3];
      end else begin
        gap++;
      end
    end
    chk("t4_changes", 32'(changes >= 8), 1);
    chk("t4_final", 32'(sout[3]), 32'(sin[3]));

    // 5: reset mid-hold with pending set on channel 4
    sin[4] = 1'b1;
    tick();                              // toggle at N
    chk("t5_rise", 32'(sout[4]), 1);
    sin[4] = 1'b0;
    tick();                              // pending sets at N+1
    reset = 1'b1;
    tick();
    chk("t5_out", 32'(sout), 0);
    chk("t5_busy", 32'(sbusy), 0);
    chk("t5_edge", 32'(seout), 0);
    reset = 1'b0;
    sin = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_quiet", 32'({sout, seout}), 0);
    end

    // 6: hold_cycles=1 is a plain one-cycle register
    last1 = s1in;
    for (int i = 0; i < 30; i++) begin
      s1in = 4'($urandom_range(0, 15));
      tick();
      chk("t6_delay", 32'(s1out), 32'(s1in));
      chk("t6_busy", 32'(s1busy), 0);
      chk("t6_edge", 32'(s1edge), 32'(s1in ^ last1));
      last1 = s1in;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
